// File: rtl/pfsoc_dsp_flow_top.sv
// Byte-serial 64-tap FIR engine: host handshake, coefficient/sample load over an
// 8-bit strobe link, one-MAC-per-cycle filter pass, then byte-wise result readback.
module pfsoc_dsp_flow_top (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SLOWCLK,
  input  logic [7:0] DATA_IN,
  input  logic       RX_RDY,
  input  logic       TX_RDY,
  output logic [7:0] DATA_OUT,
  output logic       FILTER_COMPLETE
);

  localparam int unsigned TAPS  = 64;
  localparam int unsigned NSAMP = 1024;

  localparam logic [7:0] CMD_START = 8'h39;
  localparam logic [7:0] CMD_LOAD  = 8'h68;
  localparam logic [7:0] CMD_READ  = 8'h6F;
  localparam logic [7:0] RSP_F     = 8'h46;
  localparam logic [7:0] RSP_Q     = 8'h3F;
  localparam logic [7:0] RSP_A     = 8'h61;
  localparam logic [7:0] RSP_R     = 8'h72;
  localparam logic [7:0] RSP_I     = 8'h69;
  localparam logic [7:0] RSP_D     = 8'h64;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_COEF, S_DATA, S_FILT, S_DONE, S_READ
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         resp_q, resp_d;
  logic [7:0]         data_out_q;
  logic               done_q, done_d;
  logic               rx_prev_q;
  logic [11:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]         hi_q, hi_d;
  logic [9:0]         n_q, n_d;
  logic [6:0]         k_q, k_d;
  logic signed [37:0] acc_q, acc_d;

  logic [15:0] coef_mem [TAPS];
  logic [15:0] samp_mem [NSAMP];
  logic [15:0] res_mem  [NSAMP];

  logic        coef_we, samp_we, res_we;
  logic [15:0] res_wdata;

  logic               accept;
  logic [15:0]        rd_word;
  logic [7:0]         rd_byte;
  logic signed [15:0] coef_tap, samp_tap;
  logic signed [31:0] prod;
  logic signed [37:0] acc_shr;
  logic [9:0]         samp_idx;
  logic               unused_slowclk;

  assign unused_slowclk = SLOWCLK;

  // A byte is taken only on the low-to-high transition of the strobe.
  assign accept = RX_RDY & ~rx_prev_q;

  // Readback byte order: even index = high byte, odd index = low byte.
  assign rd_word = res_mem[byte_cnt_q[10:1]];
  assign rd_byte = byte_cnt_q[0] ? rd_word[7:0] : rd_word[15:8];

  assign samp_idx = n_q - {4'd0, k_q[5:0]};
  assign coef_tap = $signed(coef_mem[k_q[5:0]]);
  // Samples before x[0] read as zero.
  assign samp_tap = ({4'd0, k_q[5:0]} <= n_q) ? $signed(samp_mem[samp_idx]) : 16'sd0;
  assign prod     = coef_tap * samp_tap;
  assign acc_shr  = acc_q >>> 15;

  always_comb begin
    if (acc_shr > 38'sd32767)       res_wdata = 16'h7FFF;
    else if (acc_shr < -38'sd32768) res_wdata = 16'h8000;
    else                            res_wdata = acc_shr[15:0];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    resp_d     = resp_q;
    done_d     = done_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    n_d        = n_q;
    k_d        = k_q;
    acc_d      = acc_q;
    coef_we    = 1'b0;
    samp_we    = 1'b0;
    res_we     = 1'b0;

    unique case (state_q)
      S_IDLE: if (accept) begin
        if (DATA_IN == CMD_START) begin
          resp_d  = RSP_F;
          state_d = S_SYNC;
        end else begin
          resp_d = RSP_Q;
        end
      end
      S_SYNC: if (accept) begin
        if (DATA_IN == CMD_LOAD) begin
          resp_d     = RSP_A;
          state_d    = S_COEF;
          byte_cnt_d = '0;
        end else begin
          resp_d  = RSP_Q;
          state_d = S_IDLE;
        end
      end
      S_COEF: if (accept) begin
        if (!byte_cnt_q[0]) hi_d    = DATA_IN;
        else                coef_we = 1'b1;
        byte_cnt_d = byte_cnt_q + 12'd1;
        if (byte_cnt_q == 12'd127) begin
          resp_d     = RSP_R;
          state_d    = S_DATA;
          byte_cnt_d = '0;
        end
      end
      S_DATA: if (accept) begin
        if (!byte_cnt_q[0]) hi_d    = DATA_IN;
        else                samp_we = 1'b1;
        byte_cnt_d = byte_cnt_q + 12'd1;
        if (byte_cnt_q == 12'd2047) begin
          resp_d     = RSP_I;
          state_d    = S_FILT;
          byte_cnt_d = '0;
          n_d        = '0;
          k_d        = '0;
          acc_d      = '0;
        end
      end
      S_FILT: begin
        // k = 0..63 are MAC cycles; k = 64 saturates and stores y[n].
        if (k_q[6]) begin
          res_we = 1'b1;
          acc_d  = '0;
          k_d    = '0;
          n_d    = n_q + 10'd1;
          if (n_q == 10'd1023) begin
            resp_d  = RSP_D;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          acc_d = acc_q + {{6{prod[31]}}, prod};
          k_d   = k_q + 7'd1;
        end
      end
      S_DONE: if (accept) begin
        if (DATA_IN == CMD_READ) begin
          resp_d     = rd_byte;
          byte_cnt_d = 12'd1;
          state_d    = S_READ;
        end else if (DATA_IN == CMD_START) begin
          resp_d  = RSP_F;
          done_d  = 1'b0;
          state_d = S_SYNC;
        end
      end
      S_READ: if (accept) begin
        if (byte_cnt_q[11]) begin
          resp_d     = RSP_D;
          byte_cnt_d = '0;
          state_d    = S_DONE;
        end else begin
          resp_d     = rd_byte;
          byte_cnt_d = byte_cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      resp_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      rx_prev_q  <= 1'b0;
      byte_cnt_q <= '0;
      hi_q       <= '0;
      n_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      resp_q     <= resp_d;
      done_q     <= done_d;
      rx_prev_q  <= RX_RDY;
      byte_cnt_q <= byte_cnt_d;
      hi_q       <= hi_d;
      n_q        <= n_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      if (TX_RDY) data_out_q <= resp_q;
    end
  end

  // NOTE: RAM arrays have no reset so they map onto plain block RAM.
  always_ff @(posedge CLK) begin
    if (coef_we) coef_mem[byte_cnt_q[6:1]]  <= {hi_q, DATA_IN};
    if (samp_we) samp_mem[byte_cnt_q[10:1]] <= {hi_q, DATA_IN};
    if (res_we)  res_mem[n_q]               <= res_wdata;
  end

  assign DATA_OUT        = data_out_q;
  assign FILTER_COMPLETE = done_q;

endmodule

// File: tb/tb_pfsoc_dsp_flow_top.sv
// Randomized bench for pfsoc_dsp_flow_top: drives the byte link and compares the
// responses and filter results with an arithmetic FIR reference model.
module tb_pfsoc_dsp_flow_top;

  logic       clk = 1'b0;
  logic       slowclk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       rx_rdy;
  logic       tx_rdy;
  logic [7:0] data_out;
  logic       filter_complete;

  pfsoc_dsp_flow_top dut (
    .CLK             (clk),
    .RESET_N         (reset_n),
    .SLOWCLK         (slowclk),
    .DATA_IN         (data_in),
    .RX_RDY          (rx_rdy),
    .TX_RDY          (tx_rdy),
    .DATA_OUT        (data_out),
    .FILTER_COMPLETE (filter_complete)
  );

  always #5  clk     = ~clk;
  always #13 slowclk = ~slowclk;

  int n_checks = 0;
  int n_pass   = 0;

  int         coef [64];
  int         samp [1024];
  int         yref [1024];
  logic [7:0] exp_bytes [2049];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic send_and_check(input logic [7:0] b, input logic [7:0] exp, input string tag);
    send_byte(b);
    @(negedge clk);
    check(tag, data_out, exp);
  endtask

  task automatic send_word(input int v);
    logic [15:0] w;
    w = 16'(v);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic gen_stimulus();
    for (int k = 0; k < 64; k++) coef[k] = int'($urandom_range(0, 4095)) - 512;
    for (int n = 0; n < 1024; n++) begin
      if (n >= 300 && n < 400)      samp[n] = 32767;
      else if (n >= 600 && n < 700) samp[n] = -32768;
      else                          samp[n] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // y[n] = sat16((sum coef[k]*x[n-k]) >>> 15), x[m] = 0 for m < 0.
  task automatic compute_ref();
    longint acc;
    logic [15:0] y16;
    for (int n = 0; n < 1024; n++) begin
      acc = 0;
      for (int k = 0; k < 64; k++)
        if (n >= k) acc += longint'(coef[k]) * longint'(samp[n-k]);
      acc = acc >>> 15;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      yref[n] = int'(acc);
      y16 = 16'(yref[n]);
      exp_bytes[2*n]   = y16[15:8];
      exp_bytes[2*n+1] = y16[7:0];
    end
    exp_bytes[2048] = 8'h64;
  endtask

  initial begin
    int cycles;
    logic [15:0] w;

    reset_n = 1'b0;
    rx_rdy  = 1'b0;
    tx_rdy  = 1'b1;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_complete", filter_complete, 1'b0);
    reset_n = 1'b1;

    // Handshake rules.
    send_and_check(8'h55, 8'h3F, "idle_other");
    send_and_check(8'h39, 8'h46, "idle_start");
    send_and_check(8'h12, 8'h3F, "sync_bad");
    send_and_check(8'h68, 8'h3F, "idle_after_sync_bad");
    send_and_check(8'h39, 8'h46, "idle_start2");
    send_and_check(8'h68, 8'h61, "sync_load");

    // Coefficient load with a strobe held high for 5 cycles on the first byte.
    gen_stimulus();
    w = 16'(coef[0]);
    @(negedge clk);
    data_in = w[15:8];
    rx_rdy  = 1'b1;
    repeat (5) @(negedge clk);
    rx_rdy  = 1'b0;
    send_byte(w[7:0]);
    for (int k = 1; k < 63; k++) send_word(coef[k]);
    w = 16'(coef[63]);
    send_byte(w[15:8]);
    @(negedge clk);
    check("coef_not_done_early", data_out, 8'h61);
    tx_rdy = 1'b0;
    send_byte(w[7:0]);
    repeat (3) @(negedge clk);
    check("tx_hold", data_out, 8'h61);
    tx_rdy = 1'b1;
    @(negedge clk);
    check("tx_release_r", data_out, 8'h72);

    // Partial sample load interrupted by reset.
    for (int i = 0; i < 350; i++) send_word(samp[i]);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_data_out", data_out, 8'h00);
    check("midreset_complete", filter_complete, 1'b0);
    reset_n = 1'b1;
    send_and_check(8'h68, 8'h3F, "midreset_idle");

    // Full run with fresh random data.
    gen_stimulus();
    compute_ref();
    send_and_check(8'h39, 8'h46, "run_start");
    send_and_check(8'h68, 8'h61, "run_load");
    for (int k = 0; k < 64; k++) send_word(coef[k]);
    @(negedge clk);
    check("run_coef_r", data_out, 8'h72);
    for (int n = 0; n < 1024; n++) send_word(samp[n]);

    cycles = 0;
    while (filter_complete !== 1'b1 && cycles < 70000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check("run_data_i", data_out, 8'h69);
    end
    check("filt_cycles", cycles, 66560);
    @(negedge clk);
    check("filt_resp_d", data_out, 8'h64);

    send_and_check(8'h00, 8'h64, "done_ignore");
    check("done_complete", filter_complete, 1'b1);

    send_byte(8'h6F);
    for (int j = 0; j < 2049; j++) begin
      @(negedge clk);
      check($sformatf("readback[%0d]", j), data_out, exp_bytes[j]);
      if (j < 2048) begin
        data_in = 8'($urandom);
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
      end
    end
    check("read_complete", filter_complete, 1'b1);

    send_and_check(8'h39, 8'h46, "done_restart");
    check("restart_clears_complete", filter_complete, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
